// File: rtl/decim_capture_ctrl_pkg.sv
// Shared definitions for the decimator capture controller.
// Holds the capture FSM state encoding and the default field widths
// used by the interface, the output register and the top level.
package decim_capture_ctrl_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int LEN_WIDTH_DEF  = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

endpackage

// File: rtl/decim_capture_ctrl_if.sv
// AXI-Stream sample port of the capture controller (DMA-facing side).
// Signals: tdata (sample), tvalid, tlast (last sample of frame), tready.
// master: the capture controller; slave: the downstream consumer.
interface decim_capture_ctrl_if
   import decim_capture_ctrl_pkg::*;
   #(parameter int DATA_WIDTH = DATA_WIDTH_DEF);

   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tlast;
   logic                  tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/decim_capture_ctrl_axis_out_reg.sv
// One-entry AXI-Stream output register with drop / overflow detection.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_load         a new sample is offered this cycle
//   i_data/i_last  sample value and its end-of-frame marker
//   i_force_last   mark the held sample as end-of-frame (capture abort)
//   i_clr_ovf      clear the sticky overflow flag (capture start)
//   o_accept       the offered sample is taken this cycle
//   o_overflow     sticky: a sample was offered while the register was stuck
//   m_axis         AXI-Stream master side
module decim_capture_ctrl_axis_out_reg
   import decim_capture_ctrl_pkg::*;
   #(parameter int DATA_WIDTH = DATA_WIDTH_DEF)
   (
      input  logic                  clk,
      input  logic                  rst,
      input  logic                  i_load,
      input  logic [DATA_WIDTH-1:0] i_data,
      input  logic                  i_last,
      input  logic                  i_force_last,
      input  logic                  i_clr_ovf,
      output logic                  o_accept,
      output logic                  o_overflow,
      decim_capture_ctrl_if.master  m_axis
   );

   logic [DATA_WIDTH-1:0] r_tdata;
   logic                  r_tvalid;
   logic                  r_tlast;
   logic                  r_overflow;
   logic                  w_xfer;
   logic                  w_drop;

   // A held sample leaving on this edge frees the slot, so a same-cycle
   // arrival refills it without a bubble.
   assign w_xfer   = r_tvalid & m_axis.tready;
   assign o_accept = i_load & (~r_tvalid | m_axis.tready);
   assign w_drop   = i_load & r_tvalid & ~m_axis.tready;

   // Output holding register and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tdata    <= {DATA_WIDTH{1'b0}};
         r_tvalid   <= 1'b0;
         r_tlast    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (o_accept) begin
            r_tdata  <= i_data;
            r_tvalid <= 1'b1;
            r_tlast  <= i_last;
         end else if (w_xfer) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
         end else if (i_force_last && r_tvalid) begin
            // only tlast may change on a stalled beat: the abort closes the frame
            r_tlast <= 1'b1;
         end
         if (i_clr_ovf) begin
            r_overflow <= 1'b0;
         end else if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign m_axis.tdata  = r_tdata;
   assign m_axis.tvalid = r_tvalid;
   assign m_axis.tlast  = r_tlast;
   assign o_overflow    = r_overflow;

endmodule

// File: rtl/decim_capture_ctrl.sv
// Capture sequencer between the register bank / trigger logic and the
// decimator. Latches the capture configuration on start, optionally waits
// for a trigger, enables the decimator and packs its samples into
// fixed-length AXI-Stream frames through a one-entry output register.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_cfg_decim/frame_len/num_frames/use_trig   capture configuration
//   i_start, i_abort, i_trig      control pulses / trigger level
//   o_dec_enable, o_dec_ratio     decimator ready and ratio (shadowed)
//   i_dec_valid, i_dec_data       decimator output sample
//   m_axis                        AXI-Stream sample output
//   o_busy, o_done, o_overflow, o_frames_done   status
module decim_capture_ctrl
   import decim_capture_ctrl_pkg::*;
   #(
      parameter int DATA_WIDTH = DATA_WIDTH_DEF,
      parameter int LEN_WIDTH  = LEN_WIDTH_DEF
   )
   (
      input  logic                  clk,
      input  logic                  rst,
      input  logic [DATA_WIDTH-1:0] i_cfg_decim,
      input  logic [LEN_WIDTH-1:0]  i_cfg_frame_len,
      input  logic [LEN_WIDTH-1:0]  i_cfg_num_frames,
      input  logic                  i_cfg_use_trig,
      input  logic                  i_start,
      input  logic                  i_abort,
      input  logic                  i_trig,
      output logic                  o_dec_enable,
      output logic [DATA_WIDTH-1:0] o_dec_ratio,
      input  logic                  i_dec_valid,
      input  logic [DATA_WIDTH-1:0] i_dec_data,
      decim_capture_ctrl_if.master  m_axis,
      output logic                  o_busy,
      output logic                  o_done,
      output logic                  o_overflow,
      output logic [LEN_WIDTH-1:0]  o_frames_done
   );

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_dec_ratio;
   logic [LEN_WIDTH-1:0]  r_frame_len;
   logic [LEN_WIDTH-1:0]  r_num_frames;
   logic [LEN_WIDTH-1:0]  r_scnt;
   logic [LEN_WIDTH-1:0]  r_frames_done;
   logic                  r_dec_enable;
   logic                  r_busy;
   logic                  r_done;

   logic w_start;
   logic w_abort;
   logic w_load;
   logic w_accept;
   logic w_frame_end;
   logic w_last_frame;

   assign w_start      = (r_state == ST_IDLE) && i_start;
   assign w_abort      = (r_state != ST_IDLE) && i_abort;
   // an abort cycle takes no new sample; only the held one is finished off
   assign w_load       = (r_state == ST_RUN) && i_dec_valid && !i_abort;
   assign w_frame_end  = (r_scnt == r_frame_len);
   assign w_last_frame = (r_num_frames != {LEN_WIDTH{1'b0}}) &&
                         ((r_frames_done + LEN_WIDTH'(1'b1)) == r_num_frames);

   decim_capture_ctrl_axis_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out_reg (
      .clk          (clk),
      .rst          (rst),
      .i_load       (w_load),
      .i_data       (i_dec_data),
      .i_last       (w_frame_end),
      .i_force_last (w_abort),
      .i_clr_ovf    (w_start),
      .o_accept     (w_accept),
      .o_overflow   (o_overflow),
      .m_axis       (m_axis)
   );

   // Capture FSM with its registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_dec_ratio   <= {DATA_WIDTH{1'b0}};
         r_frame_len   <= {LEN_WIDTH{1'b0}};
         r_num_frames  <= {LEN_WIDTH{1'b0}};
         r_scnt        <= {LEN_WIDTH{1'b0}};
         r_frames_done <= {LEN_WIDTH{1'b0}};
         r_dec_enable  <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_dec_ratio   <= i_cfg_decim;
                  r_frame_len   <= i_cfg_frame_len;
                  r_num_frames  <= i_cfg_num_frames;
                  r_scnt        <= {LEN_WIDTH{1'b0}};
                  r_frames_done <= {LEN_WIDTH{1'b0}};
                  r_busy        <= 1'b1;
                  if (i_cfg_use_trig) begin
                     r_state      <= ST_ARM;
                     r_dec_enable <= 1'b0;
                  end else begin
                     r_state      <= ST_RUN;
                     r_dec_enable <= 1'b1;
                  end
               end
            end
            ST_ARM: begin
               if (i_abort) begin
                  r_state <= ST_DRAIN;
               end else if (i_trig) begin
                  r_state      <= ST_RUN;
                  r_dec_enable <= 1'b1;
               end
            end
            ST_RUN: begin
               if (i_abort) begin
                  r_state      <= ST_DRAIN;
                  r_dec_enable <= 1'b0;
               end else if (w_accept) begin
                  if (w_frame_end) begin
                     r_scnt        <= {LEN_WIDTH{1'b0}};
                     r_frames_done <= r_frames_done + LEN_WIDTH'(1'b1);
                     if (w_last_frame) begin
                        r_state      <= ST_DRAIN;
                        r_dec_enable <= 1'b0;
                     end
                  end else begin
                     r_scnt <= r_scnt + LEN_WIDTH'(1'b1);
                  end
               end
            end
            ST_DRAIN: begin
               // the held beat leaves on this edge or the register is already empty
               if (!m_axis.tvalid || m_axis.tready) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state      <= ST_IDLE;
               r_dec_enable <= 1'b0;
               r_busy       <= 1'b0;
            end
         endcase
      end
   end

   assign o_dec_enable  = r_dec_enable;
   assign o_dec_ratio   = r_dec_ratio;
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_frames_done = r_frames_done;

endmodule
